// File: rtl/rv_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and MEM-stage data access.
// Latency: grant in the request cycle, mem_req_o the next cycle, rvalid with mem_rvalid_i (3 cycles minimum).
// Backpressure: one transaction in flight; both gnt outputs stay low until the FSM returns to IDLE.
module rv_mem_arbiter #(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [1:0]        dm_sz_i,
  input  logic              dm_sign_ext_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic              dm_err_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int SW = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  // mem_op_sz_e encoding
  localparam logic [1:0] SZ_WORD  = 2'd0;
  localparam logic [1:0] SZ_HWORD = 2'd1;
  localparam logic [1:0] SZ_BYTE  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_ERR} state_e;

  // Everything needed to drive memory and shape the response, captured at grant.
  typedef struct packed {
    logic              owner_dm;
    logic              we;
    logic [1:0]        sz;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
  } xact_t;

  state_e          state, state_nxt;
  xact_t           lat;
  logic [SW-1:0]   streak;
  logic            starve, dm_win, if_win;
  logic            dm_bad;
  logic [3:0]      dm_be;
  logic [DATA_W-1:0] dm_wd;
  logic [DATA_W-1:0] shifted, ext;
  logic            resp_hit;

  // Arbitration: data first, fetch forced through once the data streak saturates.
  always_comb begin
    starve   = if_req_i && (streak == STREAK_MAX);
    dm_win   = dm_req_i && !starve;
    if_win   = if_req_i && !dm_win;
    dm_gnt_o = (state == ST_IDLE) && !rst && dm_win;
    if_gnt_o = (state == ST_IDLE) && !rst && if_win;
  end

  // Data request decode: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    dm_bad = 1'b0;
    dm_be  = 4'b0000;
    dm_wd  = dm_wdata_i;
    case (dm_sz_i)
      SZ_WORD: begin
        dm_bad = (dm_addr_i[1:0] != 2'b00);
        dm_be  = 4'b1111;
      end
      SZ_HWORD: begin
        dm_bad = dm_addr_i[0];
        dm_be  = dm_addr_i[1] ? 4'b1100 : 4'b0011;
        dm_wd  = {2{dm_wdata_i[15:0]}};
      end
      SZ_BYTE: begin
        dm_be  = 4'b0001 << dm_addr_i[1:0];
        dm_wd  = {4{dm_wdata_i[7:0]}};
      end
      default: dm_bad = 1'b1;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (dm_gnt_o)      state_nxt = dm_bad ? ST_ERR : ST_REQ;
        else if (if_gnt_o) state_nxt = ST_REQ;
      end
      ST_REQ:  if (mem_gnt_i)    state_nxt = ST_RESP;
      ST_RESP: if (mem_rvalid_i) state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture the winner's fields; they stay stable for the rest of the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat <= '0;
    end else if (dm_gnt_o) begin
      lat <= '{owner_dm: 1'b1, we: dm_we_i, sz: dm_sz_i, sign_ext: dm_sign_ext_i,
               addr: dm_addr_i, be: dm_be, wdata: dm_wd};
    end else if (if_gnt_o) begin
      lat <= '{owner_dm: 1'b0, we: 1'b0, sz: SZ_WORD, sign_ext: 1'b0,
               addr: if_addr_i, be: 4'b1111, wdata: '0};
    end
  end

  // Consecutive data grants seen while fetch is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           streak <= '0;
    else if (!if_req_i || if_gnt_o)    streak <= '0;
    else if (dm_gnt_o && streak != STREAK_MAX) streak <= streak + SW'(1);
  end

  // Memory side is driven purely from registers.
  always_comb begin
    mem_req_o   = (state == ST_REQ);
    mem_we_o    = lat.we;
    mem_be_o    = lat.be;
    mem_addr_o  = {lat.addr[ADDR_W-1:2], 2'b00};
    mem_wdata_o = lat.wdata;
  end

  // Load data: shift the addressed lane down, then sign/zero extend by size.
  always_comb begin
    shifted = mem_rdata_i >> {lat.addr[1:0], 3'b000};
    case (lat.sz)
      SZ_BYTE:  ext = {{24{lat.sign_ext & shifted[7]}}, shifted[7:0]};
      SZ_HWORD: ext = {{16{lat.sign_ext & shifted[15]}}, shifted[15:0]};
      default:  ext = shifted;
    endcase
  end

  // Responses: only a memory response in RESP counts; rdata is zero unless its rvalid is up.
  always_comb begin
    resp_hit    = (state == ST_RESP) && mem_rvalid_i;
    if_rvalid_o = resp_hit && !lat.owner_dm;
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    dm_err_o    = (state == ST_ERR);
    dm_rvalid_o = (resp_hit && lat.owner_dm) || dm_err_o;
    dm_rdata_o  = (resp_hit && lat.owner_dm && !lat.we) ? ext : '0;
  end

endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF) and the data access of the MEM stage.
- Arbitrates between the two ports with data priority and an anti-starvation limit, keeping at most one transaction outstanding.
- Generates byte enables and lane-aligned write data, and extracts and extends load data according to the `mem_op_sz_e` / `sign_ext` controls.
- Misaligned data accesses are rejected with an error and never reach memory.

Parameters:
- ADDR_W, 64, address width; matches the pipeline PC width.
- DATA_W, 32, data width; fixed at 32, other values unsupported.
- MAX_DM_STREAK, 4, maximum consecutive data grants while a fetch request is pending.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  fetch request; held with address until if_gnt_o
- if_addr_i  in  ADDR_W  fetch address (word aligned)
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch data valid (1-cycle pulse)
- if_rdata_o  out  32  instruction word
- dm_req_i  in  1  data request; held with all dm_* fields until dm_gnt_o
- dm_we_i  in  1  1 = store, 0 = load
- dm_sz_i  in  2  `mem_op_sz_e`: WORD=0, HWORD=1, BYTE=2; 3 is illegal
- dm_sign_ext_i  in  1  sign-extend load result
- dm_addr_i  in  ADDR_W  byte address
- dm_wdata_i  in  32  store data, right-justified
- dm_gnt_o  out  1  data request accepted this cycle
- dm_rvalid_o  out  1  data response (1-cycle pulse); also issued for stores and errors
- dm_err_o  out  1  qualifies dm_rvalid_o: misaligned access or illegal size
- dm_rdata_o  out  32  extended load data; 0 on store or error
- mem_req_o  out  1  memory request; registered, held until mem_gnt_i
- mem_we_o  out  1  memory write enable
- mem_be_o  out  4  byte enables
- mem_addr_o  out  ADDR_W  address with bits [1:0] forced to 0
- mem_wdata_o  out  32  lane-replicated write data
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response; one per granted request, stores included
- mem_rdata_i  in  32  memory read word

Behaviour:
- Reset state: all outputs 0, FSM in IDLE, owner=IF, streak counter=0.
- FSM states: IDLE, REQ, RESP, ERR.
- IDLE arbitration:
  - Data wins, unless `if_req_i && streak==MAX_DM_STREAK`, in which case fetch wins.
  - The winner's gnt_o is asserted combinationally in the same cycle.
  - Its fields are latched, and mem_* are driven from registers starting next cycle.
  - Both gnt outputs are 0 outside IDLE.
- Streak counter:
  - Increments on each data grant while if_req_i=1, saturating at MAX_DM_STREAK.
  - Clears on a fetch grant, and on any cycle with if_req_i=0.
- Granted data request that is misaligned or has an illegal size:
  - Misaligned means WORD with addr[1:0]≠0, HWORD with addr[0]≠0; illegal size is dm_sz_i=3.
  - Transition IDLE→ERR; no memory request is issued.
  - ERR lasts one cycle: dm_rvalid_o=1, dm_err_o=1, dm_rdata_o=0; then return to IDLE.
- Otherwise IDLE→REQ with mem_req_o=1.
- REQ: mem_req_o and fields stay stable until mem_gnt_i, then go to RESP and drop mem_req_o in that same edge.
- RESP: on mem_rvalid_i, pulse the owner's rvalid_o combinationally in that cycle, then go to IDLE.
- Minimum cadence is 3 cycles per transaction (grant, request, response), assuming zero-wait memory that returns mem_rvalid_i the cycle after mem_gnt_i.
- mem_rvalid_i outside RESP is ignored.
- Byte enables:
  - WORD: 4'b1111.
  - HWORD: 4'b0011 << (2*addr[1]).
  - BYTE: 4'b0001 << addr[1:0].
  - Stores and loads use the same enables.
- Write data: WORD passed through; HWORD as {2{wdata[15:0]}}; BYTE as {4{wdata[7:0]}}.
- Load data:
  - Compute `mem_rdata_i >> (8*addr[1:0])` using the latched address.
  - Take the low 8/16/32 bits per size.
  - Sign-extend if sign_ext, else zero-extend.
- Fetch path: if_rdata_o = mem_rdata_i unmodified; mem_be_o=4'b1111; we=0.
- The rdata outputs hold 0 whenever the corresponding rvalid_o is 0.
- Async reset mid-transaction: immediate return to IDLE with mem_req_o=0.
- A memory response arriving after reset is dropped; requesters must re-request.

Test Plan:
- Reset with both req high: rst=1 → all outputs 0 → release rst: dm_gnt_o=1 in the first IDLE cycle, if_gnt_o=0.
- Fetch with zero-wait memory: if_addr=0x100, mem_gnt_i the cycle after mem_req_o, rvalid the next cycle with 0x00000013 → if_rvalid_o=1, if_rdata_o=0x00000013, mem_be_o=4'hF, mem_addr_o=0x100.
- Signed byte load: addr=0x203, BYTE, sign_ext=1, mem_rdata_i=0x80AABBCC → mem_be_o=4'b1000, mem_addr_o=0x200, dm_rdata_o=0xFFFFFF80; same with sign_ext=0 → 0x00000080.
- Halfword store: addr=0x42, HWORD, wdata=0x1234ABCD → mem_we_o=1, mem_be_o=4'b1100, mem_wdata_o=0xABCDABCD, dm_rvalid_o on mem_rvalid_i with dm_rdata_o=0.
- Misaligned word: addr=0x11, WORD → dm_gnt_o, no mem_req_o ever, next cycle dm_rvalid_o=1 and dm_err_o=1; same for dm_sz_i=3.
- Starvation: dm_req_i and if_req_i held high continuously → 4 data grants, then 1 fetch grant, repeating; reset asserted while in REQ → mem_req_o falls immediately, and a late mem_rvalid_i produces no rvalid_o.
